// File: rtl/instr_encoder.sv
// RISC-V style instruction encoder: packs register/immediate fields per format into a 2-entry result FIFO.
// Latency 1 cycle into an empty FIFO; in_ready drops while the FIFO holds 2 entries.
module instr_encoder #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      fmt,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [BITS-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err,
    output logic [15:0]     enc_cnt,
    output logic [15:0]     err_cnt
);

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Immediate fits the field when every bit above the field's sign bit matches it.
    logic fits_11;
    logic fits_12;
    logic fits_19;
    logic fits_20;

    assign fits_11 = (&imm[BITS-1:11]) | !(|imm[BITS-1:11]);
    assign fits_12 = (&imm[BITS-1:12]) | !(|imm[BITS-1:12]);
    assign fits_19 = (&imm[BITS-1:19]) | !(|imm[BITS-1:19]);
    assign fits_20 = (&imm[BITS-1:20]) | !(|imm[BITS-1:20]);

    logic [31:0] enc_word;
    logic        enc_bad;
    entry_t      new_entry;

    always_comb begin
        enc_word = 32'h0;
        enc_bad  = 1'b0;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_bad  = !fits_11;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_bad  = !fits_11;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_bad  = !fits_12 || imm[0];
            end
            FMT_U: begin
                enc_word = {imm[19:0], rd, opcode};
                enc_bad  = !fits_19;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_bad  = !fits_20 || imm[0];
            end
            default: enc_bad = 1'b1;
        endcase
        new_entry.err   = enc_bad;
        new_entry.instr = enc_bad ? 32'h0 : enc_word;
    end

    // Shift-style FIFO: slot0 is always the head, so the outputs come straight from a register.
    logic [1:0] count;
    entry_t     slot0;
    entry_t     slot1;
    logic       push;
    logic       pop;

    assign in_ready  = rst_n && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_instr = slot0.instr;
    assign out_err   = slot0.err;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            slot0   <= '0;
            slot1   <= '0;
            enc_cnt <= 16'h0;
            err_cnt <= 16'h0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= new_entry;
                    else               slot1 <= new_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) slot0 <= slot1;
                    count <= count - 2'd1;
                end
                // Push implies count < 2 and pop implies count > 0, so count is 1 here.
                2'b11: slot0 <= new_entry;
                default: ;
            endcase

            if (push && enc_cnt != 16'hFFFF)
                enc_cnt <= enc_cnt + 16'd1;
            if (push && new_entry.err && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule
